pe_cfg_loader: RTL and testbench
================================

// Module: pe_cfg_loader
// PURPOSE
//  Write-side driver of the PE configuration protocol (PE_inst / init / run).
//  - Accepts a valid/ready stream of PE instruction words.
//  - Clears the target PEs, then writes the words one per init pulse into their config buffers.
//  - Sequences run for a programmed cycle count.
//  - One loader broadcasts to a row/column of PEs that share one program.
// PARAMETERS
//  PE_INST_W     28  width of one PE instruction word (= `PE_inst)
//  BUFFER_DEPTH  16  PE config buffer depth (= `buffer_depth); max words/run cycles
//  CNT_W         5   width of count inputs; must hold BUFFER_DEPTH
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  start       in   1          1-cycle request; sampled only in IDLE
//  abort       in   1          return to IDLE from any state
//  inst_count  in   CNT_W      words to load, legal 1..BUFFER_DEPTH; latched on start
//  run_cycles  in   CNT_W      run length, legal 1..BUFFER_DEPTH; latched on start
//  in_valid    in   1          instruction word valid
//  in_ready    out  1          loader accepts word (combinational: state==LOAD)
//  in_inst     in   PE_INST_W  instruction word
//  pe_rst      out  1          synchronous clear to PEs (registered)
//  PE_inst     out  PE_INST_W  instruction to PEs (registered)
//  init        out  1          write strobe to PEs (registered)
//  run         out  1          execute strobe to PEs (registered)
//  busy        out  1          state != IDLE
//  done        out  1          1-cycle pulse, program completed
//  err         out  1          1-cycle pulse, start rejected (illegal count)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; all outputs 0; PE_inst=0; internal counters 0.
//  FSM states: IDLE -> CLEAR -> LOAD -> RUN -> FIN -> IDLE.
//  IDLE:
//   - If start and both counts are in 1..BUFFER_DEPTH: latch the counts; go to CLEAR.
//   - If start with either count 0 or >BUFFER_DEPTH: err=1 next cycle; stay in IDLE.
//  CLEAR:
//   - One cycle. pe_rst=1 during the following cycle, which zeroes the PE init/run counters.
//   - Go to LOAD.
//  LOAD:
//   - in_ready=1.
//   - Handshake (in_valid & in_ready) at edge k: PE_inst<=in_inst and init<=1, visible in cycle k+1.
//   - No handshake: init<=0; PE_inst holds its last value.
//   - in_valid gaps are legal; init is never asserted without a new word.
//   - Count handshakes. Handshake number inst_count goes to RUN; in_ready drops the cycle after it.
//  RUN:
//   - run=1 for exactly run_cycles consecutive cycles.
//   - First run cycle directly follows the last init cycle (no bubble). init and run are never 1 together.
//   - PE_inst is held during RUN.
//   - After the last run cycle, go to FIN.
//  FIN:
//   - done=1 for one cycle; run=0; go to IDLE.
//  busy: 1 in every state except IDLE, including the cycle in which done is high.
//  abort (highest priority after rst):
//   - Next state is IDLE; init, run and pe_rst are 0 from the next cycle.
//   - No done pulse; counters are cleared.
//   - A later start runs CLEAR again, so partially loaded PEs are reset before reload.
//  start outside IDLE: ignored.
//  Counts:
//   - Unsigned, CNT_W bits.
//   - run_cycles may differ from inst_count; the PE executes buffer entries 0..run_cycles-1.
//   - Entries beyond inst_count hold 0 (a NOP, since CLEAR/rst zeroes them).
//  Reset mid-operation: outputs drop to 0 asynchronously; the PEs are reset by the same rst.
// TESTING
//  1. rst=1 -> all outputs 0; release, start with inst_count=3, run_cycles=3, words A,B,C back-to-back
//     -> pe_rst 1 cycle; init high 3 cycles with PE_inst=A,B,C; run high 3 cycles; done pulse;
//     busy=0 after the done cycle.
//  2. Same as 1 with in_valid 1,0,0,1,1 -> init pattern 1,0,0,1,1; PE_inst holds A during the gap;
//     run starts the cycle after the 3rd init.
//  3. start with inst_count=0 -> err 1 cycle, busy stays 0.
//     start with run_cycles=17 (BUFFER_DEPTH=16) -> err 1 cycle, busy stays 0.
//  4. inst_count=16, run_cycles=16 -> exactly 16 init then 16 run cycles; in_ready low after the 16th handshake.
//  5. abort during the 2nd run cycle of a 5-cycle run -> run=0 next cycle; no done; new start re-issues pe_rst.
//  6. Assert rst asynchronously mid-LOAD -> init/in_ready drop without a clk edge; start after release works as in 1.

Source files
------------

// File: rtl/pe_cfg_loader.sv
// pe_cfg_loader
//    Write-side driver for a row/column of PEs sharing one program.
//    Clears the PEs, streams instruction words into their config buffers
//    one init pulse per accepted word, then pulses run for a programmed
//    number of cycles and reports completion with done.
module pe_cfg_loader #(
   parameter int PE_INST_W    = 28,
   parameter int BUFFER_DEPTH = 16,
   parameter int CNT_W        = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_W-1:0]     inst_count,
   input  logic [CNT_W-1:0]     run_cycles,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PE_INST_W-1:0] in_inst,
   output logic                 pe_rst,
   output logic [PE_INST_W-1:0] PE_inst,
   output logic                 init,
   output logic                 run,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
   localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] inst_cnt_r;   // words to load, latched on start
   logic [CNT_W-1:0] run_cyc_r;    // run length, latched on start
   logic [CNT_W-1:0] hs_cnt_r;     // handshakes taken so far
   logic [CNT_W-1:0] run_cnt_r;    // run pulses issued so far
   logic             hs_s;
   logic             cnt_ok_s;
   logic             last_hs_s;
   logic             run_last_s;

   assign in_ready   = (state_r == ST_LOAD);
   assign busy       = (state_r != ST_IDLE);
   assign hs_s       = in_valid & in_ready;
   assign cnt_ok_s   = (inst_count != ZERO_C) && (inst_count <= DEPTH_C) &&
                       (run_cycles != ZERO_C) && (run_cycles <= DEPTH_C);
   assign last_hs_s  = hs_s && ((hs_cnt_r + ONE_C) == inst_cnt_r);
   // The RUN state spends one extra cycle beyond the run pulses: its first
   // cycle carries the last init, so run pulses land on the following cycles.
   assign run_last_s = (state_r == ST_RUN) && (run_cnt_r == run_cyc_r);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_nx_s = state_r;
      if (abort) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && cnt_ok_s) begin
                  state_nx_s = ST_CLEAR;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_CLEAR: state_nx_s = ST_LOAD;
            ST_LOAD: begin
               if (last_hs_s) begin
                  state_nx_s = ST_RUN;
               end else begin
                  state_nx_s = ST_LOAD;
               end
            end
            ST_RUN: begin
               if (run_last_s) begin
                  state_nx_s = ST_FIN;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
            ST_FIN:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // Registered PE-facing strobes, instruction word and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pe_rst  <= 1'b0;
         init    <= 1'b0;
         run     <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         PE_inst <= {PE_INST_W{1'b0}};
      end else begin
         pe_rst <= ~abort && (state_r == ST_CLEAR);
         init   <= ~abort && hs_s;
         run    <= ~abort && (state_r == ST_RUN) && (run_cnt_r != run_cyc_r);
         done   <= ~abort && run_last_s;
         err    <= ~abort && (state_r == ST_IDLE) && start && !cnt_ok_s;
         if (hs_s && !abort) begin
            PE_inst <= in_inst;
         end
      end
   end

   // Count latches plus handshake and run counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_cnt_r <= ZERO_C;
         run_cyc_r  <= ZERO_C;
         hs_cnt_r   <= ZERO_C;
         run_cnt_r  <= ZERO_C;
      end else if (abort) begin
         hs_cnt_r  <= ZERO_C;
         run_cnt_r <= ZERO_C;
      end else begin
         case (state_r)
            ST_IDLE: begin
               hs_cnt_r  <= ZERO_C;
               run_cnt_r <= ZERO_C;
               if (start && cnt_ok_s) begin
                  inst_cnt_r <= inst_count;
                  run_cyc_r  <= run_cycles;
               end
            end
            ST_LOAD: begin
               if (hs_s) begin
                  hs_cnt_r <= hs_cnt_r + ONE_C;
               end
            end
            ST_RUN: begin
               if (!run_last_s) begin
                  run_cnt_r <= run_cnt_r + ONE_C;
               end
            end
            default: begin
               hs_cnt_r <= hs_cnt_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_cfg_loader.sv
// tb_pe_cfg_loader
//    Self-checking bench for pe_cfg_loader. Each transaction builds the
//    expected per-cycle output trace from the protocol timeline (CLEAR at
//    t=1, pe_rst at t=2, init one cycle after each handshake, run right after
//    the last init, done after the last run) and compares every cycle.
module tb_pe_cfg_loader;

   localparam int PE_INST_W    = 28;
   localparam int BUFFER_DEPTH = 16;
   localparam int CNT_W        = 5;
   localparam int VW           = PE_INST_W + 7;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic                 abort;
   logic [CNT_W-1:0]     inst_count;
   logic [CNT_W-1:0]     run_cycles;
   logic                 in_valid;
   logic                 in_ready;
   logic [PE_INST_W-1:0] in_inst;
   logic                 pe_rst;
   logic [PE_INST_W-1:0] PE_inst;
   logic                 init;
   logic                 run;
   logic                 busy;
   logic                 done;
   logic                 err;

   int                   n_tests = 0;
   int                   n_fail  = 0;
   logic [PE_INST_W-1:0] pe_last;

   pe_cfg_loader #(
      .PE_INST_W    (PE_INST_W),
      .BUFFER_DEPTH (BUFFER_DEPTH),
      .CNT_W        (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .inst_count (inst_count),
      .run_cycles (run_cycles),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_inst    (in_inst),
      .pe_rst     (pe_rst),
      .PE_inst    (PE_inst),
      .init       (init),
      .run        (run),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [VW-1:0] mk(input logic b, input logic ir, input logic pr,
                                        input logic it, input logic rn, input logic dn,
                                        input logic er, input logic [PE_INST_W-1:0] pe);
      return {b, ir, pr, it, rn, dn, er, pe};
   endfunction

   task automatic check(input string tag, input int cyc, input logic [VW-1:0] exp);
      logic [VW-1:0] obs;
      obs = {busy, in_ready, pe_rst, init, run, done, err, PE_inst};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc%0d {busy,rdy,perst,init,run,done,err,inst} obs=%h exp=%h",
                tag, cyc, obs, exp);
      end
   endtask

   // One program transaction. mode: 0 back-to-back, 1 random gaps, 2 valid 1,0,0,1,1...
   // abort_t: 0 none, >0 abort in that cycle, <0 abort at a random busy cycle.
   task automatic run_txn(input string tag, input int n, input int r, input int mode,
                          input int abort_t);
      bit                   v  [0:127];
      logic [VW-1:0]        ex [0:127];
      logic [PE_INST_W-1:0] words [0:15];
      logic [4:0]           pat;
      logic [PE_INST_W-1:0] pe;
      int                   ones, t, big_l, tend, k, ab;
      pat = 5'b11001;
      for (int i = 0; i < 16; i++) words[i] = PE_INST_W'($urandom);
      for (int i = 0; i < 128; i++) v[i] = 1'b0;
      ones = 0; t = 2; big_l = 2;
      while (ones < n) begin
         case (mode)
            0:       v[t] = 1'b1;
            1:       v[t] = (t - 2 >= 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
            default: v[t] = (t - 2 < 5) ? pat[t-2] : 1'b1;
         endcase
         if (v[t]) begin
            ones++;
            if (ones == n) big_l = t;
         end
         t++;
      end
      ab = abort_t;
      if (ab < 0) ab = int'($urandom_range(1, big_l + 2 + r));
      tend = (ab > 0) ? ab + 2 : big_l + 3 + r;
      pe = pe_last; k = 0;
      for (int tt = 0; tt <= tend; tt++) begin
         if (tt >= 3 && v[tt-1]) begin
            pe = words[k];
            k++;
         end
         ex[tt] = mk(tt >= 1 && tt <= big_l + 2 + r, tt >= 2 && tt <= big_l, tt == 2,
                     tt >= 3 && v[tt-1], tt >= big_l + 2 && tt <= big_l + 1 + r,
                     tt == big_l + 2 + r, 1'b0, pe);
         if (ab > 0 && tt > ab) ex[tt] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            ex[ab][PE_INST_W-1:0]);
      end
      k = 0;
      for (int tt = 0; tt <= tend; tt++) begin
         start      = (tt == 0) || (ex[tt][VW-1] && $urandom_range(0, 5) == 0);
         inst_count = (tt == 0) ? CNT_W'(n) : CNT_W'($urandom_range(0, 31));
         run_cycles = (tt == 0) ? CNT_W'(r) : CNT_W'($urandom_range(0, 31));
         abort      = (ab > 0 && tt == ab);
         if (tt >= 2 && tt <= big_l) begin
            in_valid = v[tt];
            if (v[tt]) begin
               in_inst = words[k];
               k++;
            end else begin
               in_inst = PE_INST_W'($urandom);
            end
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_inst  = PE_INST_W'($urandom);
         end
         @(negedge clk);
         check(tag, tt, ex[tt]);
         @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      pe_last = ex[tend][PE_INST_W-1:0];
   endtask

   // Start with illegal counts: err pulse, never busy.
   task automatic err_txn(input string tag, input int ic, input int rc);
      for (int tt = 0; tt < 3; tt++) begin
         start      = (tt == 0);
         inst_count = CNT_W'(ic);
         run_cycles = CNT_W'(rc);
         in_valid   = 1'($urandom_range(0, 1));
         in_inst    = PE_INST_W'($urandom);
         @(negedge clk);
         check(tag, tt, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tt == 1, pe_last));
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      inst_count = '0; run_cycles = '0; in_inst = '0;
      pe_last = '0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("reset", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {PE_INST_W{1'b0}}));
      @(posedge clk); #1;
      rst = 1'b0;

      run_txn("basic3x3", 3, 3, 0, 0);
      run_txn("gap10011", 3, 3, 2, 0);
      err_txn("err_ic0", 0, 3);
      err_txn("err_rc17", 3, 17);
      err_txn("err_ic17", 17, 5);
      err_txn("err_rc0", 4, 0);
      run_txn("full16x16", 16, 16, 0, 0);
      run_txn("min1x1", 1, 1, 0, 0);
      run_txn("abort_run2", 3, 5, 0, 7);
      run_txn("after_abort", 3, 5, 0, 0);
      for (int i = 0; i < 10; i++) begin
         run_txn("random", int'($urandom_range(1, 16)), int'($urandom_range(1, 16)), 1,
                 ($urandom_range(0, 2) == 0) ? -1 : 0);
      end

      // Async reset in the middle of LOAD.
      start = 1'b1; inst_count = 5'd4; run_cycles = 5'd2; in_valid = 1'b0;
      @(negedge clk);
      check("rstmid_c0", 0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pe_last));
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_inst = 28'h0ABCDEF;
      @(negedge clk);
      check("rstmid_c2", 2, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pe_last));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rstmid_c3", 3, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 28'h0ABCDEF));
      #2 rst = 1'b1;
      #1;
      check("rstmid_async", 3, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {PE_INST_W{1'b0}}));
      @(posedge clk); #1;
      rst = 1'b0;
      pe_last = '0;
      run_txn("after_rst", 3, 3, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
